// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, start-glitch rejection, parity/framing/overrun
// reporting, valid/ready output. Define UART_RX_MAJORITY_EN for 3-sample majority voting.
module uart_rx_param #(
    parameter int CLOCK     = 50000000,
    parameter int RATE      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);
    localparam int DIV  = CLOCK / RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [3:0]    LAST_IDX = 4'(DATA_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] BRK   = 3'd5;

    logic                 s1_q, rxd_s_q, h1_q;
    logic                 samp, fall, expire, complete;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shf_q, shf_d;
    logic                 ferr_q, ferr_d, perr_q, perr_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, fe_q, pe_q, ovr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b1;
            rxd_s_q <= 1'b1;
            h1_q    <= 1'b1;
        end else begin
            s1_q    <= rxd;
            rxd_s_q <= s1_q;
            h1_q    <= rxd_s_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Edge detect runs one cycle late so every expiry lands on centre+1 with the full window in hand.
    logic h2_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) h2_q <= 1'b1;
        else       h2_q <= h1_q;
    end
    assign samp = (rxd_s_q & h1_q) | (rxd_s_q & h2_q) | (h1_q & h2_q);
    assign fall = !h1_q && h2_q;
`else
    assign samp = rxd_s_q;
    assign fall = !rxd_s_q && h1_q;
`endif

    assign expire = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = expire ? cnt_q : cnt_q - 1'b1;
        idx_d    = idx_q;
        stop_d   = stop_q;
        shf_d    = shf_q;
        ferr_d   = ferr_q;
        perr_d   = perr_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                    cnt_d   = HALF_M1;
                end
            end
            START: if (expire) begin
                if (samp) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    idx_d   = '0;
                    cnt_d   = DIV_M1;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            DATA: if (expire) begin
                // LSB arrives first, so after DATA_BITS right shifts it sits at bit 0.
                shf_d = {samp, shf_q[DATA_BITS-1:1]};
                cnt_d = DIV_M1;
                if (idx_q == LAST_IDX) begin
                    state_d = (PARITY != 0) ? PAR : STOP;
                    stop_d  = 1'b0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            PAR: if (expire) begin
                perr_d  = (^shf_q) ^ samp ^ 1'(PARITY == 1);
                state_d = STOP;
                cnt_d   = DIV_M1;
                stop_d  = 1'b0;
            end
            STOP: if (expire) begin
                if (!samp) ferr_d = 1'b1;
                cnt_d = DIV_M1;
                if (stop_q == 1'(STOP_BITS - 1)) begin
                    complete = 1'b1;
                    state_d  = samp ? IDLE : BRK;
                end else begin
                    stop_d = 1'b1;
                end
            end
            BRK: if (samp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shf_q   <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shf_q   <= shf_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (complete) begin
                if (!valid_q || rx_ready) begin
                    data_q  <= shf_q;
                    fe_q    <= ferr_d;
                    pe_q    <= perr_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_frame_err  = fe_q;
    assign rx_parity_err = pe_q;
    assign rx_overrun    = ovr_q;
    assign rx_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at DIV=16: 8N1, 8E1 and 8N2 instances share clock and reset.
module tb_uart_rx_param;
    localparam int DIV = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 155;
`else
    localparam int LAT = 154;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd [3];
    logic       rdy [3];
    logic [7:0] dat [3];
    logic       vld [3];
    logic       fe  [3];
    logic       pe  [3];
    logic       ovr [3];
    logic       busy[3];

    int n_chk = 0, n_err = 0;
    int vcyc[3], acc[3], ocnt[3];
    logic [7:0] acc_d [3];
    logic       acc_fe[3], acc_pe[3];
    int lat, bc, a0, v0, o0;
    logic [15:0] f;

    always #5 clk = ~clk;

    uart_rx_param #(.CLOCK(1600000), .RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .rxd(rxd[0]), .rx_ready(rdy[0]), .rx_data(dat[0]), .rx_valid(vld[0]),
        .rx_frame_err(fe[0]), .rx_parity_err(pe[0]), .rx_overrun(ovr[0]), .rx_busy(busy[0]));
    uart_rx_param #(.CLOCK(1600000), .RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .rxd(rxd[1]), .rx_ready(rdy[1]), .rx_data(dat[1]), .rx_valid(vld[1]),
        .rx_frame_err(fe[1]), .rx_parity_err(pe[1]), .rx_overrun(ovr[1]), .rx_busy(busy[1]));
    uart_rx_param #(.CLOCK(1600000), .RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .rxd(rxd[2]), .rx_ready(rdy[2]), .rx_data(dat[2]), .rx_valid(vld[2]),
        .rx_frame_err(fe[2]), .rx_parity_err(pe[2]), .rx_overrun(ovr[2]), .rx_busy(busy[2]));

    initial begin
        for (int i = 0; i < 3; i++) begin
            vcyc[i] = 0; acc[i] = 0; ocnt[i] = 0;
            acc_d[i] = '0; acc_fe[i] = 1'b0; acc_pe[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i]) vcyc[i]++;
            if (ovr[i]) ocnt[i]++;
            if (vld[i] && rdy[i]) begin
                acc[i]++;
                acc_d[i]  = dat[i];
                acc_fe[i] = fe[i];
                acc_pe[i] = pe[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame bits LSB first (start bit at f[0]); spike_bit inverts that bit for one cycle at its centre.
    task automatic send(input int ch, input logic [15:0] fr, input int nb, input int spike_bit);
        for (int b = 0; b < nb; b++)
            for (int k = 0; k < DIV; k++) begin
                rxd[ch] = (b == spike_bit && k == DIV / 2) ? ~fr[b] : fr[b];
                @(negedge clk);
            end
        rxd[ch] = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin rxd[i] = 1'b1; rdy[i] = 1'b1; end
        repeat (3) @(negedge clk);
        chk("rst_valid", vld[0], 0);
        chk("rst_data",  dat[0], 0);
        chk("rst_busy",  busy[0], 0);
        chk("rst_ovr",   ovr[0], 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 0xA5: latency and single-cycle valid pulse
        a0 = acc[0]; v0 = vcyc[0];
        f = {6'h3f, 1'b1, 8'hA5, 1'b0};
        lat = 0;
        fork
            send(0, f, 10, -1);
            begin
                @(posedge clk);
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk);
                    lat++;
                    #1;
                    if (vld[0]) break;
                end
            end
        join
        repeat (10) @(negedge clk);
        chk("a5_latency", lat, LAT);
        chk("a5_data", acc_d[0], 8'hA5);
        chk("a5_ferr", acc_fe[0], 0);
        chk("a5_perr", acc_pe[0], 0);
        chk("a5_count", acc[0] - a0, 1);
        chk("a5_vwidth", vcyc[0] - v0, 1);

        // even parity, 0x03 (two ones): parity bit 1 is wrong, 0 is right
        f = {5'h1f, 1'b1, 1'b1, 8'h03, 1'b0};
        send(1, f, 11, -1);
        repeat (10) @(negedge clk);
        chk("par1_data", acc_d[1], 8'h03);
        chk("par1_perr", acc_pe[1], 1);
        f = {5'h1f, 1'b1, 1'b0, 8'h03, 1'b0};
        send(1, f, 11, -1);
        repeat (10) @(negedge clk);
        chk("par0_data", acc_d[1], 8'h03);
        chk("par0_perr", acc_pe[1], 0);
        chk("par_count", acc[1], 2);

        // 5-cycle start glitch
        a0 = acc[0];
        rxd[0] = 1'b0;
        repeat (5) @(negedge clk);
        rxd[0] = 1'b1;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy[0]) bc++;
        end
        chk("glitch_busy_seen", bc > 0, 1);
        chk("glitch_busy_max", bc <= DIV / 2 + 2, 1);
        chk("glitch_novalid", acc[0] - a0, 0);
        chk("glitch_idle", busy[0], 0);

        // overrun: hold off the consumer across two frames
        rdy[0] = 1'b0;
        o0 = ocnt[0]; a0 = acc[0];
        send(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10, -1);
        send(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10, -1);
        repeat (10) @(negedge clk);
        chk("ovr_hold_data", dat[0], 8'h11);
        chk("ovr_hold_valid", vld[0], 1);
        chk("ovr_pulses", ocnt[0] - o0, 1);
        rdy[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ovr_drop_valid", vld[0], 0);
        chk("ovr_acc_data", acc_d[0], 8'h11);
        chk("ovr_acc_count", acc[0] - a0, 1);

        // 8N2: second stop bit low, then a 3-frame break
        a0 = acc[2];
        send(2, {4'hf, 1'b0, 1'b1, 8'h5A, 1'b0}, 12, -1);
        repeat (20) @(negedge clk);
        chk("stop2_data", acc_d[2], 8'h5A);
        chk("stop2_ferr", acc_fe[2], 1);
        chk("stop2_count", acc[2] - a0, 1);
        a0 = acc[2];
        rxd[2] = 1'b0;
        repeat (3 * 12 * DIV) @(negedge clk);
        chk("brk_busy", busy[2], 1);
        chk("brk_count", acc[2] - a0, 1);
        chk("brk_data", acc_d[2], 8'h00);
        chk("brk_ferr", acc_fe[2], 1);
        rxd[2] = 1'b1;
        repeat (40) @(negedge clk);
        chk("brk_exit_idle", busy[2], 0);
        chk("brk_no_more", acc[2] - a0, 1);

        // reset in the middle of data bit 4 of 0x5A
        f = {6'h3f, 1'b1, 8'h5A, 1'b0};
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < DIV; k++) begin
                rxd[0] = f[b];
                @(negedge clk);
            end
        rxd[0] = f[5];
        repeat (DIV / 2) @(negedge clk);
        chk("mid_busy_pre", busy[0], 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_data", dat[0], 0);
        chk("mid_rst_valid", vld[0], 0);
        rxd[0] = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        a0 = acc[0];
        send(0, {6'h3f, 1'b1, 8'h3C, 1'b0}, 10, -1);
        repeat (10) @(negedge clk);
        chk("post_rst_data", acc_d[0], 8'h3C);
        chk("post_rst_count", acc[0] - a0, 1);
        chk("post_rst_ferr", acc_fe[0], 0);

`ifdef UART_RX_MAJORITY_EN
        a0 = acc[0];
        send(0, {6'h3f, 1'b1, 8'h3C, 1'b0}, 10, 3);
        repeat (10) @(negedge clk);
        chk("spike_data", acc_d[0], 8'h3C);
        chk("spike_count", acc[0] - a0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8-bit, 9600-baud receiver.
- Configurable data width, parity mode, stop-bit count and baud divisor.
- Adds start-bit glitch rejection, framing/parity/overrun error reporting, and a valid/ready output handshake.
- Sits between the board RXD pin and the packet/command parser.

Parameters:
- CLOCK, 50000000, system clock frequency in Hz.
- RATE, 9600, baud rate in bit/s. DIV = CLOCK/RATE (integer divide); HALF = DIV/2. DIV >= 8 required.
- DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked: 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high.
- rxd  input  1  serial line, asynchronous, idle high.
- rx_ready  input  1  consumer accepts the current word.
- rx_data  output  DATA_BITS  received word.
- rx_valid  output  1  rx_data and the error flags are valid.
- rx_frame_err  output  1  a stop bit was sampled 0; qualified by rx_valid.
- rx_parity_err  output  1  parity mismatch; qualified by rx_valid; always 0 when PARITY=0.
- rx_overrun  output  1  one-cycle pulse: a frame completed while rx_valid=1 and it was dropped.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0, rx_overrun=0, rx_busy=0. Synchroniser flops = 1, FSM = IDLE, counters = 0.
- rxd passes through a 2-flop synchroniser (rxd_s). All sampling uses rxd_s.
- Baud counter width is $clog2(DIV+1). It is reloaded on every state entry.
- FSM:
  - IDLE: when rxd_s is 0 (previous rxd_s was 1) -> START; counter loads HALF-1.
  - START: when the counter reaches 0, sample rxd_s. If 1 -> IDLE (glitch; no flag, no output). If 0 -> DATA, bit index = 0, counter = DIV-1.
  - DATA: on each counter expiry, shift the sample into bit[index]. After index DATA_BITS-1 -> PARITY if PARITY != 0, else STOP.
  - PARITY: one sample. Odd mode: error if XOR(data, parity bit) != 1. Even mode: error if XOR != 0.
  - STOP: STOP_BITS samples, each at DIV spacing. Any 0 sample sets the frame error. After the last sample, complete the frame (below). Then go to IDLE if the final sample was 1, else to BREAK.
  - BREAK: wait until rxd_s = 1, then -> IDLE. This prevents false starts during a line break.
- Every sample is taken at the bit centre: start edge + HALF + n*DIV cycles (after synchroniser delay).
- Frame completion, same cycle as the last stop sample:
  - rx_valid=0 or rx_ready=1: load rx_data and both error flags; set rx_valid=1.
  - Otherwise: keep the old word, pulse rx_overrun for 1 cycle, drop the new frame.
- Frames with a framing or parity error are still delivered, with their flag set.
- Handshake:
  - rx_valid clears on the cycle after rx_valid & rx_ready, unless a new frame completes in that same cycle, in which case it stays 1 with the new data.
  - rx_data and the error flags are stable while rx_valid=1 and rx_ready=0.
- Latency: rx_valid rises 2 (synchroniser) + HALF + (1+DATA_BITS+P+STOP_BITS-1)*DIV cycles after the rxd falling edge, where P = 1 if PARITY != 0 else 0.
- Reset mid-frame: abort immediately, discard the partial word, return to reset values.
- rx_overrun and rx_valid never assert while reset = 1.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each sample (start, data, parity, stop) is the majority of rxd_s at centre-1, centre and centre+1 cycles. The decision is registered at centre+1, so all output timings shift by +1 cycle.
- Undefined: single sample at the centre cycle. No extra flops.

Test Plan:
- CLOCK=1600000, RATE=100000 (DIV=16), 8N1, rx_ready=1: send 0xA5 -> rx_valid pulses 1 cycle, rx_data=0xA5, both error flags 0; rx_valid rises 2+8+9*16 = 154 cycles after the start edge.
- PARITY=2 (even), send 0x03 with parity bit 1 -> rx_valid=1, rx_parity_err=1, rx_data=0x03. Same frame with parity bit 0 -> rx_parity_err=0.
- 5-cycle low glitch on idle rxd -> FSM returns to IDLE, rx_valid stays 0, rx_busy high for at most HALF+2 cycles.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun pulses once at the completion of 0x22. Then set rx_ready=1 -> rx_valid drops next cycle.
- STOP_BITS=2, second stop bit driven 0 -> rx_frame_err=1. rxd held low for 3 frame times -> exactly one frame is delivered, data=0x00 with frame error, FSM stays in BREAK until rxd goes high, no further frames.
- reset asserted at data bit 4 of 0x5A -> outputs return to reset values immediately. A frame of 0x3C sent after release is received correctly. With UART_RX_MAJORITY_EN, a 1-cycle inverted spike at a data-bit centre does not corrupt the byte.
